// File: rtl/clcg_seq_ctrl.sv
// clcg_seq_ctrl
//   Sequencer for the dual-CLCG pseudorandom bit generator. Holds the four
//   seed bytes, pulses the core load, discards a warm-up run of bits, then
//   packs the serial generator bit into WORD_W-bit words delivered on a
//   valid/ready port. The core is stalled via core_en under back-pressure,
//   and can optionally be reloaded every RESEED_WORDS words.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   cfg_we/addr/data   : seed byte write (0=x, 1=y, 2=p, 3=q)
//   seed_out[31:0]     : {q,p,y,x} to the core seed inputs
//   go, halt           : start (IDLE only) / stop generation
//   busy               : state != IDLE
//   core_load, core_en : core start pulse / advance enable
//   core_bit           : generator output bit (valid in core_en cycles)
//   out_data/valid/ready : packed word handshake
//   word_cnt[15:0]     : words produced since last go
module clcg_seq_ctrl #(
   parameter int unsigned WORD_W       = 8,
   parameter int unsigned WARMUP       = 16,
   parameter int unsigned RESEED_WORDS = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [1:0]        cfg_addr,
   input  logic [7:0]        cfg_data,
   output logic [31:0]       seed_out,
   input  logic              go,
   input  logic              halt,
   output logic              busy,
   output logic              core_load,
   output logic              core_en,
   input  logic              core_bit,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       word_cnt
);

   localparam int unsigned    CW        = $clog2(WORD_W);
   localparam logic [CW-1:0]  BIT_LAST  = CW'(WORD_W - 1);
   localparam logic [31:0]    WARM_LAST = (WARMUP > 0) ? 32'(WARMUP - 1) : 32'd0;
   localparam logic [31:0]    RS_WORDS  = 32'(RESEED_WORDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WARM,
      S_RUN
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         seed_q, seed_d;
   // Only WORD_W-1 history bits are kept; the newest bit comes straight
   // from core_bit when a word completes.
   logic [WORD_W-2:0]   sh_q, sh_d;
   logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [31:0]         warm_cnt_q, warm_cnt_d;
   logic [15:0]         rs_cnt_q, rs_cnt_d;
   logic [WORD_W-1:0]   out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic [15:0]         word_cnt_q, word_cnt_d;

   logic                stall;
   logic                bit_last;
   logic                word_done;
   logic [WORD_W-1:0]   word_next;
   logic [15:0]         rs_next;

   assign bit_last  = (bit_cnt_q == BIT_LAST);
   assign stall     = out_valid_q & ~out_ready & bit_last;
   assign word_next = {sh_q, core_bit};
   assign rs_next   = rs_cnt_q + 16'd1;

   always_comb begin
      state_d     = state_q;
      seed_d      = seed_q;
      sh_d        = sh_q;
      bit_cnt_d   = bit_cnt_q;
      warm_cnt_d  = warm_cnt_q;
      rs_cnt_d    = rs_cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      word_cnt_d  = word_cnt_q;
      core_load   = 1'b0;
      core_en     = 1'b0;
      word_done   = 1'b0;

      if (cfg_we) begin
         case (cfg_addr)
            2'd0:    seed_d[7:0]   = cfg_data;
            2'd1:    seed_d[15:8]  = cfg_data;
            2'd2:    seed_d[23:16] = cfg_data;
            default: seed_d[31:24] = cfg_data;
         endcase
      end

      case (state_q)
         S_IDLE: begin
            if (go && !halt) begin
               state_d    = S_LOAD;
               word_cnt_d = '0;
            end
         end
         S_LOAD: begin
            core_load  = 1'b1;
            bit_cnt_d  = '0;
            rs_cnt_d   = '0;
            warm_cnt_d = '0;
            if (halt) state_d = S_IDLE;
            else      state_d = (WARMUP == 0) ? S_RUN : S_WARM;
         end
         S_WARM: begin
            if (halt) begin
               state_d   = S_IDLE;
               bit_cnt_d = '0;
            end else begin
               core_en = 1'b1;
               if (warm_cnt_q == WARM_LAST) state_d = S_RUN;
               else                         warm_cnt_d = warm_cnt_q + 32'd1;
            end
         end
         default: begin
            if (halt) begin
               state_d   = S_IDLE;
               bit_cnt_d = '0;
            end else begin
               core_en = ~stall;
               if (!stall) begin
                  sh_d = word_next[WORD_W-2:0];
                  if (bit_last) begin
                     word_done  = 1'b1;
                     bit_cnt_d  = '0;
                     word_cnt_d = word_cnt_q + 16'd1;
                     rs_cnt_d   = rs_next;
                     if ((RESEED_WORDS != 0) && (32'(rs_next) == RS_WORDS))
                        state_d = S_LOAD;
                  end else begin
                     bit_cnt_d = bit_cnt_q + CW'(1);
                  end
               end
            end
         end
      endcase

      // A word can only complete when the output slot is free or being
      // drained this cycle, so a pending word is never overwritten.
      if (word_done) begin
         out_data_d  = word_next;
         out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         seed_q      <= 32'h0403_0201;
         sh_q        <= '0;
         bit_cnt_q   <= '0;
         warm_cnt_q  <= '0;
         rs_cnt_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         word_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         seed_q      <= seed_d;
         sh_q        <= sh_d;
         bit_cnt_q   <= bit_cnt_d;
         warm_cnt_q  <= warm_cnt_d;
         rs_cnt_q    <= rs_cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

   assign seed_out  = seed_q;
   assign busy      = (state_q != S_IDLE);
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_clcg_seq_ctrl.sv
// Bench for clcg_seq_ctrl: two instances (A: WARMUP=4, no reseed;
// B: WARMUP=0, reseed every 2 words) share the control inputs and are
// compared every cycle against a behavioural model, plus directed checks.
module tb_clcg_seq_ctrl;

   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1, cfg_we = 1'b0, go = 1'b0, halt = 1'b0, out_ready = 1'b0;
   logic [1:0] cfg_addr = '0;
   logic [7:0] cfg_data = '0;
   logic       core_bit_a, core_bit_b = 1'b0;

   logic [31:0] seed_out_a, seed_out_b;
   logic        busy_a, busy_b, core_load_a, core_load_b, core_en_a, core_en_b;
   logic        out_valid_a, out_valid_b;
   logic [7:0]  out_data_a, out_data_b;
   logic [15:0] word_cnt_a, word_cnt_b;

   // stub core for A: bits consumed in core_en cycles from a fixed table
   bit bits_a [0:4095];
   int consA = 0;
   assign core_bit_a = bits_a[consA % 4096];

   clcg_seq_ctrl #(.WORD_W(W), .WARMUP(4), .RESEED_WORDS(0)) dut_a (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .seed_out(seed_out_a), .go(go), .halt(halt), .busy(busy_a),
      .core_load(core_load_a), .core_en(core_en_a), .core_bit(core_bit_a),
      .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
      .word_cnt(word_cnt_a));

   clcg_seq_ctrl #(.WORD_W(W), .WARMUP(0), .RESEED_WORDS(2)) dut_b (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .seed_out(seed_out_b), .go(go), .halt(halt), .busy(busy_b),
      .core_load(core_load_b), .core_en(core_en_b), .core_bit(core_bit_b),
      .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
      .word_cnt(word_cnt_b));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 load, 2 warm-up, 3 run
   typedef struct {
      int          mode;
      int          warm_done;
      int          nbits;
      int          acc;
      int          since;
      logic        pend;
      logic [7:0]  pend_data;
      logic [15:0] words;
      logic [31:0] seed;
   } mdl_t;

   mdl_t mA, mB;

   function automatic mdl_t mreset();
      mdl_t m;
      m.mode = 0; m.warm_done = 0; m.nbits = 0; m.acc = 0; m.since = 0;
      m.pend = 1'b0; m.pend_data = '0; m.words = '0; m.seed = 32'h0403_0201;
      return m;
   endfunction

   function automatic logic model_en(input mdl_t m, input logic h, input logic rdy);
      if (h || m.mode == 0 || m.mode == 1) return 1'b0;
      if (m.mode == 2) return 1'b1;
      return !(m.pend && !rdy && m.nbits == W - 1);
   endfunction

   function automatic void mstep(inout mdl_t m, input logic r, g, h, we,
                                 input logic [1:0] a, input logic [7:0] d,
                                 input logic rdy, cb, input int warmup, reseed);
      logic en, done;
      logic [7:0] w;
      if (r) begin
         m = mreset();
         return;
      end
      en = model_en(m, h, rdy);
      done = 1'b0;
      w = '0;
      if (we) m.seed[int'(a)*8 +: 8] = d;
      case (m.mode)
         0: if (g && !h) begin m.mode = 1; m.words = '0; end
         1: if (h) m.mode = 0;
            else begin
               m.nbits = 0; m.acc = 0; m.since = 0; m.warm_done = 0;
               m.mode = (warmup == 0) ? 3 : 2;
            end
         2: if (h) begin m.mode = 0; m.nbits = 0; m.acc = 0; end
            else begin
               m.warm_done++;
               if (m.warm_done == warmup) m.mode = 3;
            end
         default:
            if (h) begin m.mode = 0; m.nbits = 0; m.acc = 0; end
            else if (en) begin
               m.acc = m.acc * 2 + int'(cb);
               m.nbits++;
               if (m.nbits == W) begin
                  done = 1'b1;
                  w = 8'(m.acc);
                  m.acc = 0; m.nbits = 0;
                  m.words = m.words + 16'd1;
                  m.since++;
                  if (reseed != 0 && m.since == reseed) m.mode = 1;
               end
            end
      endcase
      if (done) begin m.pend = 1'b1; m.pend_data = w; end
      else if (m.pend && rdy) m.pend = 1'b0;
   endfunction

   task automatic cmp(input string p, input mdl_t m, input logic e,
                      input logic b, cl, ce, ov, input logic [7:0] od,
                      input logic [15:0] wc, input logic [31:0] so);
      check({p, ".busy"},      b,  32'(m.mode != 0));
      check({p, ".core_load"}, cl, 32'(m.mode == 1));
      check({p, ".core_en"},   ce, 32'(e));
      check({p, ".out_valid"}, ov, 32'(m.pend));
      check({p, ".out_data"},  od, 32'(m.pend_data));
      check({p, ".word_cnt"},  wc, 32'(m.words));
      check({p, ".seed_out"},  so, m.seed);
   endtask

   int loadsA = 0, loadsB = 0;

   // one clock: compare at negedge, advance models, then move past posedge
   task automatic tick();
      logic usedA;
      @(negedge clk);
      cmp("A", mA, model_en(mA, halt, out_ready), busy_a, core_load_a, core_en_a,
          out_valid_a, out_data_a, word_cnt_a, seed_out_a);
      cmp("B", mB, model_en(mB, halt, out_ready), busy_b, core_load_b, core_en_b,
          out_valid_b, out_data_b, word_cnt_b, seed_out_b);
      usedA = (core_en_a === 1'b1);
      if (core_load_a === 1'b1) loadsA++;
      if (core_load_b === 1'b1) loadsB++;
      mstep(mA, rst, go, halt, cfg_we, cfg_addr, cfg_data, out_ready, core_bit_a, 4, 0);
      mstep(mB, rst, go, halt, cfg_we, cfg_addr, cfg_data, out_ready, core_bit_b, 0, 2);
      @(posedge clk);
      #1;
      if (usedA) consA++;
      core_bit_b = 1'($urandom_range(0, 1));
   endtask

   initial begin
      int n;
      logic [7:0] exp2, pd;
      logic [15:0] wc;
      logic [7:0] seeds [4];

      for (int i = 0; i < 4096; i++) bits_a[i] = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) bits_a[i] = 1'b1;
      for (int i = 0; i < 8; i++) bits_a[4 + i] = (8'hB2 >> (7 - i)) & 1'b1;
      exp2 = '0;
      for (int i = 12; i < 20; i++) exp2 = {exp2[6:0], bits_a[i]};

      mA = mreset();
      mB = mreset();
      @(posedge clk);
      #1;
      tick();
      rst = 1'b0;
      check("reset.seed_out", seed_out_a, 32'h0403_0201);
      check("reset.word_cnt", word_cnt_a, 32'd0);

      // seed writes
      seeds = '{8'hA5, 8'h3C, 8'h77, 8'h19};
      for (int i = 0; i < 4; i++) begin
         cfg_we = 1'b1; cfg_addr = 2'(i); cfg_data = seeds[i];
         tick();
      end
      cfg_we = 1'b0;
      check("seed.value", seed_out_a, 32'h1977_3CA5);
      check("seed.busy", busy_a, 32'd0);
      check("seed.no_load", loadsA, 0);

      // first run, no back-pressure
      out_ready = 1'b1;
      consA = 0;
      go = 1'b1;
      tick();
      go = 1'b0;
      check("run.load_pulse", core_load_a, 32'd1);
      tick();
      check("run.load_once", core_load_a, 32'd0);
      check("run.warm_en", core_en_a, 32'd1);
      n = 0;
      while (out_valid_a !== 1'b1 && n < 40) begin tick(); n++; end
      check("run.first_word_lat", n, 12);
      check("run.first_word", out_data_a, 32'hB2);
      check("run.word_cnt", word_cnt_a, 32'd1);
      check("run.loads", loadsA, 1);
      // B reloads on the cycle after its second word completes
      repeat (4) tick();
      check("reseed.load_pulse", core_load_b, 32'd1);
      check("reseed.loads", loadsB, 1);
      repeat (9) tick();
      check("reseed.word_cnt", word_cnt_b, 32'd3);
      check("reseed.loads2", loadsB, 2);

      // back-pressure run
      halt = 1'b1; tick(); halt = 1'b0;
      repeat (2) tick();
      out_ready = 1'b0;
      consA = 0;
      go = 1'b1; tick(); go = 1'b0;
      repeat (30) tick();
      check("bp.consumed_stall", consA, 19);
      check("bp.held_valid", out_valid_a, 32'd1);
      check("bp.held_data", out_data_a, 32'hB2);
      check("bp.stalled", core_en_a, 32'd0);
      out_ready = 1'b1;
      tick();
      check("bp.word2_valid", out_valid_a, 32'd1);
      check("bp.word2_data", out_data_a, 32'(exp2));
      check("bp.consumed", consA, 20);
      check("bp.word_cnt", word_cnt_a, 32'd2);

      // halt mid-word with a pending word
      out_ready = 1'b0;
      n = 0;
      while (!(mA.mode == 3 && mA.pend && mA.nbits == 5) && n < 100) begin tick(); n++; end
      check("halt.reached", 32'(n < 100), 32'd1);
      pd = mA.pend_data;
      wc = mA.words;
      halt = 1'b1; tick(); halt = 1'b0;
      check("halt.busy", busy_a, 32'd0);
      check("halt.core_en", core_en_a, 32'd0);
      repeat (20) tick();
      check("halt.pend_valid", out_valid_a, 32'd1);
      check("halt.pend_data", out_data_a, 32'(pd));
      check("halt.no_new_word", word_cnt_a, 32'(wc));
      out_ready = 1'b1;
      tick();
      check("halt.drained", out_valid_a, 32'd0);
      go = 1'b1; tick(); go = 1'b0;
      check("halt.restart_busy", busy_a, 32'd1);
      check("halt.restart_cnt", word_cnt_a, 32'd0);

      // go together with halt in IDLE
      halt = 1'b1; tick(); halt = 1'b0;
      tick();
      go = 1'b1; halt = 1'b1; tick(); go = 1'b0; halt = 1'b0;
      check("gohalt.busy", busy_a, 32'd0);
      check("gohalt.load", core_load_a, 32'd0);

      // reset in RUN
      cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 8'h5A; tick(); cfg_we = 1'b0;
      go = 1'b1; tick(); go = 1'b0;
      repeat (15) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      check("rst.busy", busy_a, 32'd0);
      check("rst.valid", out_valid_a, 32'd0);
      check("rst.data", out_data_a, 32'd0);
      check("rst.word_cnt", word_cnt_a, 32'd0);
      check("rst.seed", seed_out_a, 32'h0403_0201);
      check("rst.core_en", core_en_a, 32'd0);
      check("rst.core_load", core_load_a, 32'd0);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         go        = ($urandom_range(0, 19) == 0);
         halt      = ($urandom_range(0, 79) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         cfg_we    = ($urandom_range(0, 9) == 0);
         cfg_addr  = 2'($urandom_range(0, 3));
         cfg_data  = 8'($urandom_range(0, 255));
         rst       = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst = 1'b0; go = 1'b0; halt = 1'b0; cfg_we = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
